// File: rtl/status_value_reader.sv
// Drains completed entries from the head of a status vector into a 2-deep output buffer.
// Handshake: a transfer happens on any rising edge where valid_o && ready_i; data_o holds until then.
module status_value_reader #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             enable_i,
    input  logic             flush_i,
    input  logic             head_valid_i,
    input  logic             head_done_i,
    input  logic [WIDTH-1:0] head_value_i,
    output logic             pull_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             stall_o,
    output logic             flush_done_o,
    output logic [15:0]      read_count_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] STALL_AT = 16'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       count_q;
    logic [WIDTH-1:0] entry0_q;
    logic [WIDTH-1:0] entry1_q;
    logic [15:0]      wait_q;
    logic [15:0]      read_count_q;
    logic             stall_q;
    logic             flush_done_q;

    logic pop;
    logic space;
    logic wr;
    logic flush_start;
    logic wait_cond;

    assign valid_o      = (count_q != 2'd0);
    assign data_o       = entry0_q;
    assign pop          = valid_o & ready_i;
    assign space        = (count_q < 2'd2) | pop;
    assign flush_start  = flush_i & (state_q != FLUSH);
    assign stall_o      = stall_q;
    assign flush_done_o = flush_done_q;
    assign read_count_o = read_count_q;
    assign state_o      = state_q;

    // A pull in the cycle flush is requested still shifts the vector, but its value is discarded.
    assign wr = pull_o & (state_q == READ) & ~flush_i;

    assign wait_cond = (state_q == READ) & head_valid_i & ~head_done_i & ~flush_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pull_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (enable_i) begin
                    state_d = READ;
                end
            end
            READ: begin
                pull_o = head_valid_i & head_done_i & space;
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (!enable_i) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                // Drain one entry per cycle regardless of its status bit.
                pull_o = head_valid_i;
                if (!head_valid_i) begin
                    state_d = enable_i ? READ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            count_q  <= 2'd0;
            entry0_q <= '0;
            entry1_q <= '0;
        end else if (flush_start) begin
            count_q <= 2'd0;
        end else begin
            case ({wr, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        entry0_q <= head_value_i;
                    end else begin
                        entry1_q <= head_value_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    // Oldest leaves while the new value joins behind the survivor.
                    if (count_q == 2'd1) begin
                        entry0_q <= head_value_i;
                    end else begin
                        entry0_q <= entry1_q;
                        entry1_q <= head_value_i;
                    end
                end
                default: begin
                    count_q <= count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wait_q  <= 16'd0;
            stall_q <= 1'b0;
        end else begin
            if (wait_cond) begin
                wait_q <= (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
            end else begin
                wait_q <= 16'd0;
            end
            stall_q <= wait_cond & (stall_q | (wait_q >= STALL_AT));
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            flush_done_q <= 1'b0;
            read_count_q <= 16'd0;
        end else begin
            flush_done_q <= (state_q == FLUSH) & ~head_valid_i;
            read_count_q <= read_count_q + {15'd0, pop};
        end
    end

    pull_needs_head : assert property (@(posedge clk_i) disable iff (!arst_n_i)
        pull_o |-> head_valid_i);

    count_in_range : assert property (@(posedge clk_i) disable iff (!arst_n_i)
        count_q <= 2'd2);

endmodule

// File: tb/tb_status_value_reader.sv
// Bench for status_value_reader: a status-vector model feeds the head, a scoreboard checks the output stream.
module tb_status_value_reader;

    logic        clk_i;
    logic        arst_n_i;
    logic        enable_i;
    logic        flush_i;
    logic        head_valid_i;
    logic        head_done_i;
    logic [7:0]  head_value_i;
    logic        pull_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        stall_o;
    logic        flush_done_o;
    logic [15:0] read_count_o;
    logic [1:0]  state_o;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic        vdone_q[$];
    logic [7:0]  vval_q[$];
    logic [15:0] exp_rc = 16'd0;
    logic        flushing = 1'b0;
    logic        pull_seen = 1'b0;

    status_value_reader #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .enable_i     (enable_i),
        .flush_i      (flush_i),
        .head_valid_i (head_valid_i),
        .head_done_i  (head_done_i),
        .head_value_i (head_value_i),
        .pull_o       (pull_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .stall_o      (stall_o),
        .flush_done_o (flush_done_o),
        .read_count_o (read_count_o),
        .state_o      (state_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Vector model and scoreboard monitor: sample at negedge, shift/drive head 2 units after posedge.
    always begin
        logic [7:0] exp;
        @(negedge clk_i);
        pull_seen = pull_o;
        checks++;
        if (pull_o === 1'b1 && head_valid_i !== 1'b1) begin
            errors++;
            $display("FAIL pull_without_head: pull_o=%b head_valid_i=%b", pull_o, head_valid_i);
        end
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pop: data_o=%h with empty expected queue", data_o);
            end else begin
                exp = exp_q.pop_front();
                if (data_o !== exp) begin
                    errors++;
                    $display("FAIL sb_data: data_o=%h expected %h", data_o, exp);
                end
            end
            exp_rc = exp_rc + 16'd1;
        end
        if (pull_o === 1'b1 && head_valid_i === 1'b1 && !flushing && arst_n_i === 1'b1) begin
            exp_q.push_back(head_value_i);
        end
        @(posedge clk_i);
        #2;
        if (pull_seen && vval_q.size() > 0) begin
            void'(vval_q.pop_front());
            void'(vdone_q.pop_front());
        end
        if (vval_q.size() > 0) begin
            head_valid_i = 1'b1;
            head_done_i  = vdone_q[0];
            head_value_i = vval_q[0];
        end else begin
            head_valid_i = 1'b0;
            head_done_i  = 1'b0;
            head_value_i = 8'h00;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_entry(input logic done, input logic [7:0] value);
        vdone_q.push_back(done);
        vval_q.push_back(value);
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0;
        enable_i = 1'b0;
        flush_i  = 1'b0;
        ready_i  = 1'b0;
        head_valid_i = 1'b0;
        head_done_i  = 1'b0;
        head_value_i = 8'h00;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: valid_o=%b data_o=%h expected 0/00", valid_o, data_o);
        end
        checks++;
        if (stall_o !== 1'b0 || flush_done_o !== 1'b0 || pull_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: stall=%b flush_done=%b pull=%b expected 0", stall_o, flush_done_o, pull_o);
        end
        checks++;
        if (read_count_o !== 16'd0 || state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: read_count=%h state=%0d expected 0000/IDLE", read_count_o, state_o);
        end
        step();
        arst_n_i = 1'b1;
    endtask

    task automatic test_single();
        enable_i = 1'b1;
        ready_i  = 1'b1;
        step();
        push_entry(1'b1, 8'hA5);
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b1 || state_o !== ST_READ) begin
            errors++;
            $display("FAIL single_pull: pull_o=%b state=%0d expected 1/READ", pull_o, state_o);
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: valid_o=%b data_o=%h expected 1/a5", valid_o, data_o);
        end
        @(negedge clk_i);
        checks++;
        if (read_count_o !== 16'd1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_count: read_count=%h valid_o=%b expected 0001/0", read_count_o, valid_o);
        end
    endtask

    task automatic test_fifo_full();
        ready_i = 1'b0;
        step();
        push_entry(1'b1, 8'h01);
        push_entry(1'b1, 8'h02);
        push_entry(1'b1, 8'h03);
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pull1: pull_o=%b expected 1", pull_o);
        end
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pull2: pull_o=%b expected 1", pull_o);
        end
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h01) begin
            errors++;
            $display("FAIL full_block: pull=%b valid=%b data=%h expected 0/1/01", pull_o, valid_o, data_o);
        end
        step();
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b1 || data_o !== 8'h01) begin
            errors++;
            $display("FAIL full_pull_with_pop: pull=%b data=%h expected 1/01", pull_o, data_o);
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h02) begin
            errors++;
            $display("FAIL full_order2: valid=%b data=%h expected 1/02", valid_o, data_o);
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h03) begin
            errors++;
            $display("FAIL full_order3: valid=%b data=%h expected 1/03", valid_o, data_o);
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: valid=%b expected 0", valid_o);
        end
    endtask

    task automatic test_stall();
        int early;
        early = 0;
        ready_i = 1'b1;
        step();
        push_entry(1'b0, 8'h3C);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            if (stall_o !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL stall_early: stall_o high in %0d of first 16 cycles, expected 0", early);
        end
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_set: stall_o=%b expected 1", stall_o);
        end
        step();
        vdone_q[0] = 1'b1;
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_pull: pull_o=%b expected 1", pull_o);
        end
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h3C) begin
            errors++;
            $display("FAIL stall_clear: stall=%b valid=%b data=%h expected 0/1/3c", stall_o, valid_o, data_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_flush();
        int bad;
        logic [15:0] rc0;
        bad = 0;
        ready_i = 1'b0;
        step();
        push_entry(1'b1, 8'h11);
        @(negedge clk_i);
        step();
        push_entry(1'b0, 8'h21);
        push_entry(1'b1, 8'h22);
        push_entry(1'b0, 8'h23);
        push_entry(1'b1, 8'h24);
        rc0 = exp_rc;
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h11) begin
            errors++;
            $display("FAIL flush_pre: pull=%b valid=%b data=%h expected 0/1/11", pull_o, valid_o, data_o);
        end
        step();
        flush_i  = 1'b1;
        flushing = 1'b1;
        exp_q.delete();
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (pull_o !== 1'b1) bad++;
            if (i == 0) begin
                checks++;
                if (valid_o !== 1'b0 || state_o !== ST_FLUSH) begin
                    errors++;
                    $display("FAIL flush_entry: valid=%b state=%0d expected 0/FLUSH", valid_o, state_o);
                end
                step();
                flush_i = 1'b1;
            end else if (i == 1) begin
                step();
                flush_i = 1'b0;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_pulls: %0d of 4 drain cycles without pull, expected 0", bad);
        end
        @(negedge clk_i);
        checks++;
        if (pull_o !== 1'b0 || flush_done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_tail: pull=%b flush_done=%b expected 0/0", pull_o, flush_done_o);
        end
        @(negedge clk_i);
        checks++;
        if (flush_done_o !== 1'b1 || state_o !== ST_READ) begin
            errors++;
            $display("FAIL flush_done: flush_done=%b state=%0d expected 1/READ", flush_done_o, state_o);
        end
        @(negedge clk_i);
        checks++;
        if (flush_done_o !== 1'b0 || read_count_o !== rc0) begin
            errors++;
            $display("FAIL flush_after: flush_done=%b read_count=%h expected 0/%h", flush_done_o, read_count_o, rc0);
        end
        step();
        flushing = 1'b0;
    endtask

    task automatic test_enable_drop();
        ready_i = 1'b0;
        step();
        push_entry(1'b1, 8'h5A);
        push_entry(1'b1, 8'h5B);
        @(negedge clk_i);
        @(negedge clk_i);
        step();
        enable_i = 1'b0;
        @(negedge clk_i);
        step();
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (state_o !== ST_IDLE || valid_o !== 1'b1 || data_o !== 8'h5A) begin
            errors++;
            $display("FAIL idle_keep: state=%0d valid=%b data=%h expected IDLE/1/5a", state_o, valid_o, data_o);
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h5B) begin
            errors++;
            $display("FAIL idle_pop2: valid=%b data=%h expected 1/5b", valid_o, data_o);
        end
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty: valid=%b expected 0", valid_o);
        end
        step();
        enable_i = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        ready_i = 1'b1;
        while (n < 200 && (vval_q.size() != 0 || exp_q.size() != 0)) begin
            step();
            n++;
        end
        @(negedge clk_i);
        checks++;
        if (vval_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: vector=%0d expected_queue=%0d left, expected 0/0", name, vval_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            push_entry(1'b1, 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 60; i++) begin
            step();
            ready_i = 1'($urandom_range(0, 1));
        end
        drain("b2b");
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        ready_i  = 1'b1;
        enable_i = 1'b1;
        while (n < 70000 && exp_rc != 16'hFFFF) begin
            step();
            n++;
            if (exp_rc != 16'hFFFF && vval_q.size() < 3) begin
                push_entry(1'b1, 8'($urandom_range(0, 255)));
            end
        end
        ready_i = 1'b0;
        checks++;
        if (exp_rc != 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_timeout: model count=%h after %0d cycles, expected ffff", exp_rc, n);
        end
        @(negedge clk_i);
        checks++;
        if (read_count_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff: read_count=%h expected ffff", read_count_o);
        end
        step();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (read_count_o !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: read_count=%h expected 0000", read_count_o);
        end
        drain("wrap");
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        step();
        push_entry(1'b1, 8'h71);
        push_entry(1'b1, 8'h72);
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h71) begin
            errors++;
            $display("FAIL areset_pre: valid=%b data=%h expected 1/71", valid_o, data_o);
        end
        #2;
        arst_n_i = 1'b0;
        vval_q.delete();
        vdone_q.delete();
        exp_q.delete();
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== 8'h00 || read_count_o !== 16'd0) begin
            errors++;
            $display("FAIL areset_out: valid=%b data=%h read_count=%h expected 0/00/0000", valid_o, data_o, read_count_o);
        end
        checks++;
        if (stall_o !== 1'b0 || flush_done_o !== 1'b0 || pull_o !== 1'b0 || state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL areset_flags: stall=%b flush_done=%b pull=%b state=%0d expected 0/0/0/IDLE", stall_o, flush_done_o, pull_o, state_o);
        end
        exp_rc = 16'd0;
        step();
        step();
        arst_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL areset_release_hold: state=%0d expected IDLE", state_o);
        end
        @(negedge clk_i);
        checks++;
        if (state_o !== ST_READ) begin
            errors++;
            $display("FAIL areset_release_run: state=%0d expected READ", state_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_stall();
        test_flush();
        test_enable_drop();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_single();
        drain("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_value_reader.md
STATUS_VALUE_READER -- requirements
Module: status_value_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of one status value entry.
REQ-002 SHALL have parameter TIMEOUT, default 16, head-not-done cycle count before stall_o; legal range 2..65535.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  reader run enable.
REQ-006 SHALL have port flush_i  input  1  single-cycle request to drain and discard the vector and the output buffer.
REQ-007 SHALL have port head_valid_i  input  1  valid bit of vector entry [0].
REQ-008 SHALL have port head_done_i  input  1  status ("set") bit of entry [0]; 1 = entry completed and readable.
REQ-009 SHALL have port head_value_i  input  WIDTH  value of entry [0].
REQ-010 SHALL have port pull_o  output  1  combinational pull strobe to the vector; the vector shifts on the same edge.
REQ-011 SHALL have port data_o  output  WIDTH  registered downstream data, head of output buffer.
REQ-012 SHALL have port valid_o  output  1  downstream valid.
REQ-013 SHALL have port ready_i  input  1  downstream ready.
REQ-014 SHALL have port stall_o  output  1  registered timeout flag.
REQ-015 SHALL have port flush_done_o  output  1  registered one-cycle pulse at flush completion.
REQ-016 SHALL have port read_count_o  output  16  registered count of completed downstream transfers.

Function
REQ-017 SHALL contain a 2-entry output FIFO (count 0..2). valid_o = (count != 0). data_o = oldest entry.
REQ-018 SHALL define pop = valid_o & ready_i; a pop removes the oldest entry at the clock edge.
REQ-019 SHALL define space = (count < 2) | pop.
REQ-020 SHALL have FSM states IDLE, READ, FLUSH.
REQ-021 IDLE: pull_o=0. Goes to READ when enable_i=1. Goes to FLUSH on flush_i.
REQ-022 READ: pull_o = head_valid_i & head_done_i & space. Goes to IDLE when enable_i=0 and no flush_i. Goes to FLUSH on flush_i.
REQ-023 On READ with pull_o=1, head_value_i SHALL be written into the FIFO at the same edge. Latency: head done with FIFO empty at cycle N gives pull_o at N and valid_o=1 at N+1.
REQ-024 Back-to-back pulls SHALL be supported: one pull per cycle while the head stays valid, done, and space=1.
REQ-025 A simultaneous pull-write and pop at count=2 SHALL leave count at 2 with order preserved.
REQ-026 A pull-write into an empty FIFO in the same cycle as no pop SHALL give count 1.
REQ-027 FLUSH: valid_o forced 0 and FIFO count cleared on entry. pull_o = head_valid_i regardless of head_done_i, one pull per cycle, data discarded.
REQ-028 FLUSH exit: when head_valid_i=0, flush_done_o pulses for one cycle. Next state is READ if enable_i=1, else IDLE.
REQ-029 flush_i SHALL be ignored while in FLUSH.
REQ-030 read_count_o SHALL increment by 1 per pop and wrap 0xFFFF to 0x0000. Flush does not clear it.
REQ-031 A 16-bit wait counter SHALL count READ cycles with head_valid_i=1 and head_done_i=0, and SHALL clear otherwise.
REQ-032 stall_o SHALL set when the wait counter reaches TIMEOUT-1 and stay set while the condition persists. It clears on the cycle after head_done_i=1, head_valid_i=0, leaving READ, or flush entry.
REQ-033 pull_o SHALL never assert when head_valid_i=0.
REQ-034 enable_i falling SHALL NOT drop FIFO contents; the downstream may continue to pop in IDLE.

Reset
REQ-035 While arst_n_i=0: state=IDLE, FIFO count=0, valid_o=0, data_o=0, stall_o=0, flush_done_o=0, read_count_o=0, wait counter=0, pull_o=0.
REQ-036 Reset assertion mid-transfer SHALL discard the FIFO contents immediately (asynchronous). Release SHALL be synchronized to clk_i edge behaviour, with the first state change no earlier than the first rising edge after release.

Verification
REQ-037 Test: enable=1, head valid+done value 0xA5, ready=1 -> pull_o=1 at N, data_o=0xA5 with valid_o=1 at N+1, read_count_o=1 at N+2.
REQ-038 Test: 3 done entries 0x01,0x02,0x03 with ready=0 -> exactly 2 pulls, pull_o=0 third cycle. Then ready=1 -> outputs 01,02,03 in order, with the third pull coinciding with the first pop.
REQ-039 Test: head valid, done=0 for TIMEOUT=16 cycles -> stall_o=1 after cycle 16. Then done=1 -> pull_o=1 and stall_o=0 next cycle.
REQ-040 Test: 4 entries (2 not done) + FIFO holding 1, flush_i pulse -> valid_o=0 next cycle, 4 consecutive pull_o, flush_done_o single pulse, read_count_o unchanged.
REQ-041 Test: read_count_o preloaded to 0xFFFF via 65535 pops, then one more pop -> 0x0000.
REQ-042 Test: arst_n_i=0 asserted between clock edges with count=2 -> valid_o=0 and all outputs zero immediately, before the next edge.
